// File: rtl/legv8_pkg.sv
// Shared LEGv8 core constants: PC-function encodings, instruction size and the
// fetch state encodings used by the instruction fetch unit.
package legv8_pkg;

    localparam logic [1:0] PS_HOLD   = 2'b00;
    localparam logic [1:0] PS_INC    = 2'b01;
    localparam logic [1:0] PS_LOAD   = 2'b10;
    localparam logic [1:0] PS_BRANCH = 2'b11;

    localparam logic [63:0] INSTR_BYTES = 64'd4;

    // A single state bit, so the WAIT encoding can drive imem_req directly.
    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_WAIT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read channel between the fetch unit (master) and the
// instruction memory (slave).
interface instruction_fetch_unit_if;

    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;

    modport master (output imem_req, imem_addr, input  imem_rdata, imem_ack);
    modport slave  (input  imem_req, imem_addr, output imem_rdata, imem_ack);

endinterface

// File: rtl/pc_next_logic.sv
// Combinational next-PC computation: hold, increment, absolute load with
// alignment check, and branch relative to the address of the current instruction.
module pc_next_logic
    import legv8_pkg::*;
(
    input  logic [1:0]  ps,
    input  logic [63:0] pc,
    input  logic [63:0] ir_pc,
    input  logic [63:0] pc_in,
    output logic [63:0] pc_next,
    output logic        misalign_set
);

    // NOTE: every output gets a default before the case, so no path can infer a latch.
    always_comb begin
        pc_next      = pc;
        misalign_set = 1'b0;
        case (ps)
            PS_INC:    pc_next = pc + INSTR_BYTES;
            PS_LOAD: begin
                pc_next      = {pc_in[63:2], 2'b00};
                misalign_set = |pc_in[1:0];
            end
            // Upper two offset bits fall off the shift; the add wraps modulo 2^64.
            PS_BRANCH: pc_next = ir_pc + (pc_in << 2);
            default:   pc_next = pc;
        endcase
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// LEGv8 multicycle PC / instruction register: sequences PC updates and issues
// variable-latency instruction-memory reads that land in I.
module instruction_fetch_unit
    import legv8_pkg::*;
#(
    parameter logic [63:0] PC_RESET = 64'h0
)(
    input  logic                      clock,
    input  logic                      reset,
    input  logic [1:0]                PS,
    input  logic                      PCsel,
    input  logic                      IL,
    input  logic [63:0]               constant,
    input  logic [63:0]               reg_a,
    output logic [31:0]               I,
    output logic [63:0]               PC,
    output logic                      fetch_busy,
    output logic                      misalign,
    instruction_fetch_unit_if.master  imem
);

    fetch_state_t state, state_next;
    logic [63:0]  ir_pc;
    logic [63:0]  pc_in;
    logic [63:0]  pc_next;
    logic [1:0]   ps_pend;
    logic [1:0]   ps_eff;
    logic         misalign_set;
    logic         capture_ps;
    logic         load_ir;

    assign pc_in = PCsel ? constant : reg_a;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= FETCH_IDLE;
        else        state <= state_next;
    end

    // Control inputs only act in IDLE; a completing fetch applies the pending PS,
    // where anything but hold is treated as an increment.
    always_comb begin
        state_next = state;
        ps_eff     = PS_HOLD;
        capture_ps = 1'b0;
        load_ir    = 1'b0;
        case (state)
            FETCH_IDLE: begin
                if (IL) begin
                    state_next = FETCH_WAIT;
                    capture_ps = 1'b1;
                end else begin
                    ps_eff = PS;
                end
            end
            FETCH_WAIT: begin
                if (imem.imem_ack) begin
                    state_next = FETCH_IDLE;
                    load_ir    = 1'b1;
                    ps_eff     = (ps_pend == PS_HOLD) ? PS_HOLD : PS_INC;
                end
            end
            default: state_next = FETCH_IDLE;
        endcase
    end

    pc_next_logic u_pc_next (
        .ps           (ps_eff),
        .pc           (PC),
        .ir_pc        (ir_pc),
        .pc_in        (pc_in),
        .pc_next      (pc_next),
        .misalign_set (misalign_set)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            PC       <= PC_RESET;
            ir_pc    <= PC_RESET;
            I        <= 32'h0;
            misalign <= 1'b0;
            ps_pend  <= PS_HOLD;
        end else begin
            PC <= pc_next;
            if (misalign_set) misalign <= 1'b1;
            if (capture_ps)   ps_pend  <= PS;
            if (load_ir) begin
                I     <= imem.imem_rdata;
                ir_pc <= PC;
            end
        end
    end

    assign fetch_busy     = (state == FETCH_WAIT);
    assign imem.imem_req  = fetch_busy;
    assign imem.imem_addr = PC;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: an architectural model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_instruction_fetch_unit;
    import legv8_pkg::*;

    localparam logic [63:0] PC_RST = 64'h100;

    logic        clock;
    logic        reset;
    logic [1:0]  PS;
    logic        PCsel;
    logic        IL;
    logic [63:0] constant;
    logic [63:0] reg_a;
    logic [31:0] I;
    logic [63:0] PC;
    logic        fetch_busy;
    logic        misalign;

    instruction_fetch_unit_if imem_bus ();

    instruction_fetch_unit #(.PC_RESET(PC_RST)) dut (
        .clock      (clock),
        .reset      (reset),
        .PS         (PS),
        .PCsel      (PCsel),
        .IL         (IL),
        .constant   (constant),
        .reg_a      (reg_a),
        .I          (I),
        .PC         (PC),
        .fetch_busy (fetch_busy),
        .misalign   (misalign),
        .imem       (imem_bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Architectural model: what the PC / IR must hold after each edge.
    logic [63:0] m_pc    = PC_RST;
    logic [63:0] m_ir_pc = PC_RST;
    logic [31:0] m_i     = 32'h0;
    logic        m_mis   = 1'b0;
    logic        m_busy  = 1'b0;
    logic [1:0]  m_pend  = PS_HOLD;
    logic [63:0] sel_val;

    initial begin
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                m_pc = PC_RST; m_ir_pc = PC_RST; m_i = 32'h0;
                m_mis = 1'b0; m_busy = 1'b0; m_pend = PS_HOLD;
            end else if (m_busy) begin
                if (imem_bus.imem_ack) begin
                    m_i     = imem_bus.imem_rdata;
                    m_ir_pc = m_pc;
                    if (m_pend != PS_HOLD) m_pc = m_pc + 64'd4;
                    m_busy  = 1'b0;
                end
            end else if (IL) begin
                m_busy = 1'b1;
                m_pend = PS;
            end else begin
                sel_val = PCsel ? constant : reg_a;
                case (PS)
                    PS_INC:    m_pc = m_pc + 64'd4;
                    PS_LOAD: begin
                        m_pc = sel_val - (sel_val % 64'd4);
                        if ((sel_val % 64'd4) != 64'd0) m_mis = 1'b1;
                    end
                    PS_BRANCH: m_pc = m_ir_pc + sel_val * 64'd4;
                    default: ;
                endcase
            end
        end
    end

    // Compare process: registered outputs are checked against the model mid-cycle.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                check("cyc_pc",   PC, m_pc);
                check("cyc_i",    64'(I), 64'(m_i));
                check("cyc_busy", 64'(fetch_busy), 64'(m_busy));
                check("cyc_req",  64'(imem_bus.imem_req), 64'(m_busy));
                check("cyc_mis",  64'(misalign), 64'(m_mis));
                if (m_busy) check("cyc_addr", imem_bus.imem_addr, m_pc);
            end
        end
    end

    task automatic idle_op(input logic [1:0] ps, input logic sel,
                           input logic [63:0] cval, input logic [63:0] aval);
        IL = 1'b0; PS = ps; PCsel = sel; constant = cval; reg_a = aval;
        @(negedge clock);
        PS = PS_HOLD;
    endtask

    // Issue a fetch; ack arrives k cycles after IL is sampled. Optionally drive
    // conflicting controls throughout the wait.
    task automatic do_fetch(input logic [1:0] ps, input int k, input logic [31:0] data,
                            input bit junk, input logic [63:0] exp_addr,
                            output int busy_cycles);
        IL = 1'b1; PS = ps;
        @(negedge clock);
        IL = 1'b0; PS = PS_HOLD;
        busy_cycles = 0;
        for (int c = 1; c <= k; c++) begin
            if (fetch_busy) busy_cycles++;
            check("fetch_addr", imem_bus.imem_addr, exp_addr);
            if (junk) begin
                IL = 1'b1; PS = PS_LOAD; PCsel = 1'b0; reg_a = 64'h999;
            end
            if (c == k) begin
                imem_bus.imem_ack   = 1'b1;
                imem_bus.imem_rdata = data;
            end
            @(negedge clock);
        end
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'hFFFF_FFFF;
        IL = 1'b0; PS = PS_HOLD;
        check("fetch_done", 64'(fetch_busy), 64'd0);
    endtask

    initial begin
        int bc;
        reset = 1'b0; PS = PS_HOLD; PCsel = 1'b0; IL = 1'b0;
        constant = 64'h0; reg_a = 64'h0;
        imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = 32'h0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        check("rst_pc",  PC, 64'h100);
        check("rst_i",   64'(I), 64'h0);
        check("rst_req", 64'(imem_bus.imem_req), 64'd0);
        check("rst_mis", 64'(misalign), 64'd0);

        // Fetch at 0x100 with three-cycle ack.
        do_fetch(PS_INC, 3, 32'h8B02_0020, 1'b0, 64'h100, bc);
        check("f1_busy_cycles", 64'(bc), 64'd3);
        check("f1_i",  64'(I), 64'h8B02_0020);
        check("f1_pc", PC, 64'h104);

        // Relative branches from an instruction fetched at 0x200.
        idle_op(PS_LOAD, 1'b0, 64'h0, 64'h200);
        check("load_pc", PC, 64'h200);
        do_fetch(PS_HOLD, 2, 32'hD280_0000, 1'b0, 64'h200, bc);
        check("f2_pc", PC, 64'h200);
        idle_op(PS_BRANCH, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0);
        check("br_neg_pc", PC, 64'h1F8);
        idle_op(PS_BRANCH, 1'b1, 64'h3, 64'h0);
        check("br_pos_pc", PC, 64'h20C);
        idle_op(PS_INC, 1'b0, 64'h0, 64'h0);
        check("inc_pc", PC, 64'h210);
        idle_op(PS_HOLD, 1'b0, 64'h0, 64'h0);
        check("hold_pc", PC, 64'h210);

        // Misaligned absolute load is forced aligned and flagged stickily.
        idle_op(PS_LOAD, 1'b0, 64'h0, 64'h3002);
        check("mis_pc",  PC, 64'h3000);
        check("mis_set", 64'(misalign), 64'd1);
        do_fetch(PS_INC, 2, 32'h1111_2222, 1'b0, 64'h3000, bc);
        check("mis_pc2",    PC, 64'h3004);
        check("mis_sticky", 64'(misalign), 64'd1);

        // Controls ignored during WAIT; pending 1x acts as increment.
        do_fetch(PS_INC, 3, 32'h3333_4444, 1'b1, 64'h3004, bc);
        check("junk_pc", PC, 64'h3008);
        check("junk_i",  64'(I), 64'h3333_4444);
        do_fetch(PS_LOAD, 1, 32'h5555_6666, 1'b0, 64'h3008, bc);
        check("pend_load_pc", PC, 64'h300C);
        do_fetch(PS_BRANCH, 1, 32'h7777_8888, 1'b0, 64'h300C, bc);
        check("pend_br_pc", PC, 64'h3010);

        // Ack while idle has no effect.
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clock);
        imem_bus.imem_ack = 1'b0;
        check("idle_ack_i",    64'(I), 64'h7777_8888);
        check("idle_ack_busy", 64'(fetch_busy), 64'd0);

        // Reset in the middle of a fetch, then a late ack.
        IL = 1'b1; PS = PS_INC;
        @(negedge clock);
        IL = 1'b0; PS = PS_HOLD;
        check("mid_busy", 64'(fetch_busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_pc",  PC, 64'h100);
        check("mid_rst_i",   64'(I), 64'h0);
        check("mid_rst_req", 64'(imem_bus.imem_req), 64'd0);
        check("mid_rst_mis", 64'(misalign), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h0BAD_0BAD;
        @(negedge clock);
        imem_bus.imem_ack = 1'b0;
        check("late_ack_i",    64'(I), 64'h0);
        check("late_ack_pc",   PC, 64'h100);
        check("late_ack_busy", 64'(fetch_busy), 64'd0);

        // PC wrap on a minimum-latency fetch.
        idle_op(PS_LOAD, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
        check("wrap_load_pc", PC, 64'hFFFF_FFFF_FFFF_FFFC);
        do_fetch(PS_INC, 1, 32'hF840_0020, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, bc);
        check("wrap_busy_cycles", 64'(bc), 64'd1);
        check("wrap_i",   64'(I), 64'hF840_0020);
        check("wrap_pc",  PC, 64'h0);
        check("wrap_mis", 64'(misalign), 64'd0);

        repeat (2) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
